// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load funct3 encodings and writeback FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_WB   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/reg_writeback_load_align.sv
// Load data alignment: selects the addressed byte/half and sign- or zero-extends it.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      // LW and the unused encodings pass the word through untouched
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// RV32I writeback stage: merges ALU results and one outstanding load onto the
// register file write port, and exposes the pending-load register for hazard stalls.
module reg_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_AW-1:0]    alu_rd,
  input  logic [XLEN-1:0]      alu_result,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [REG_AW-1:0]    ld_rd,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_addr_lo,
  output logic                 ld_ready,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 mem_rready,
  output logic                 RegWr,
  output logic [REG_AW-1:0]    write_reg,
  output logic [XLEN-1:0]      write_data,
  output logic [2**REG_AW-1:0] pend_mask
);

  wb_state_t         state;
  logic [REG_AW-1:0] ld_rd_q;
  logic [2:0]        ld_funct3_q;
  logic [1:0]        ld_addr_lo_q;
  logic [XLEN-1:0]   ld_data_q;
  logic [XLEN-1:0]   aligned;
  logic              alu_acc;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (ld_funct3_q),
    .addr_lo (ld_addr_lo_q),
    .rdata   (mem_rdata),
    .data    (aligned)
  );

  assign ld_ready   = (state == IDLE);
  assign mem_rready = (state == LOAD_WAIT);
  assign alu_ready  = (state != LOAD_WB);
  assign alu_acc    = alu_valid && alu_ready;

  always_comb begin
    pend_mask = '0;
    if (state != IDLE && ld_rd_q != '0)
      pend_mask[ld_rd_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ld_rd_q      <= '0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
      ld_data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_issue) begin
            ld_rd_q      <= ld_rd;
            ld_funct3_q  <= ld_funct3;
            ld_addr_lo_q <= ld_addr_lo;
            state        <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (mem_rvalid) begin
            ld_data_q <= aligned;
            state     <= LOAD_WB;
          end
        end
        LOAD_WB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The load owns the port in LOAD_WB; alu_ready is low then, so the ALU never collides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWr      <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (state == LOAD_WB) begin
      RegWr      <= (ld_rd_q != '0);
      write_reg  <= ld_rd_q;
      write_data <= ld_data_q;
    end else if (alu_acc) begin
      RegWr      <= (alu_rd != '0);
      write_reg  <= alu_rd;
      write_data <= alu_result;
    end else begin
      RegWr      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: write-port scoreboard plus per-scenario checks.
module tb_reg_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rready;
  logic        RegWr;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pend_mask;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  reg_writeback #(.XLEN(32), .REG_AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .alu_ready  (alu_ready),
    .ld_issue   (ld_issue),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_ready   (ld_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rready (mem_rready),
    .RegWr      (RegWr),
    .write_reg  (write_reg),
    .write_data (write_data),
    .pend_mask  (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // Advance to the next falling edge and retire any register-file write against the scoreboard.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (RegWr === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: got x%0d=%h, required no write", write_reg, write_data);
      end else begin
        e = sb.pop_front();
        if (write_reg !== e.rd || write_data !== e.data) begin
          n_err++;
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h", write_reg, write_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_issue = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    n_cmp++; if (RegWr !== 1'b0)      begin n_err++; $display("FAIL rst_regwr: got %b, required 0", RegWr); end
    n_cmp++; if (write_reg !== 5'd0)  begin n_err++; $display("FAIL rst_write_reg: got %0d, required 0", write_reg); end
    n_cmp++; if (write_data !== 32'd0) begin n_err++; $display("FAIL rst_write_data: got %h, required 0", write_data); end
    n_cmp++; if (pend_mask !== 32'd0) begin n_err++; $display("FAIL rst_pend: got %h, required 0", pend_mask); end
    n_cmp++; if (ld_ready !== 1'b1)   begin n_err++; $display("FAIL rst_ld_ready: got %b, required 1", ld_ready); end
    n_cmp++; if (alu_ready !== 1'b1)  begin n_err++; $display("FAIL rst_alu_ready: got %b, required 1", alu_ready); end
    n_cmp++; if (mem_rready !== 1'b0) begin n_err++; $display("FAIL rst_mem_rready: got %b, required 0", mem_rready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_write();
    alu_valid = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b, required 1", alu_ready); end
    sb.push_back('{5'd5, 32'hDEADBEEF});
    tick();
    alu_valid = 0;
    n_cmp++; if (RegWr !== 1'b1) begin n_err++; $display("FAIL alu_regwr: got %b, required 1", RegWr); end
    n_cmp++; if (write_reg !== 5'd5) begin n_err++; $display("FAIL alu_write_reg: got %0d, required 5", write_reg); end
    n_cmp++; if (write_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL alu_write_data: got %h, required deadbeef", write_data); end
    tick();
    n_cmp++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL alu_pulse: got %b, required 0", RegWr); end
  endtask

  // One complete load: issue, wait 'delay' cycles for memory, then check the writeback.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] rdata, input int unsigned delay, input logic [31:0] exp);
    logic [31:0] pm;
    pm = (rd != 0) ? (32'h1 << rd) : 32'h0;
    ld_issue = 1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo;
    n_cmp++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL ld_issue_ready: got %b, required 1", ld_ready); end
    tick();
    ld_issue = 0;
    for (int unsigned i = 1; i < delay; i++) begin
      n_cmp++; if (pend_mask !== pm) begin n_err++; $display("FAIL ld_pend_wait: got %h, required %h", pend_mask, pm); end
      tick();
    end
    n_cmp++; if (mem_rready !== 1'b1) begin n_err++; $display("FAIL ld_mem_rready: got %b, required 1", mem_rready); end
    mem_rvalid = 1; mem_rdata = rdata;
    if (rd != 0) sb.push_back('{rd, exp});
    tick();
    mem_rvalid = 0;
    n_cmp++; if (pend_mask !== pm) begin n_err++; $display("FAIL ld_pend_wb: got %h, required %h", pend_mask, pm); end
    n_cmp++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL ld_wb_ready: got alu=%b ld=%b, required 0 0", alu_ready, ld_ready); end
    n_cmp++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL ld_early_write: got %b, required 0", RegWr); end
    tick();
    n_cmp++; if (RegWr !== (rd != 0)) begin n_err++; $display("FAIL ld_regwr: got %b, required %b", RegWr, rd != 0); end
    n_cmp++; if (write_reg !== rd || write_data !== exp) begin n_err++; $display("FAIL ld_data: got x%0d=%h, required x%0d=%h", write_reg, write_data, rd, exp); end
    n_cmp++; if (pend_mask !== 32'd0 || ld_ready !== 1'b1) begin n_err++; $display("FAIL ld_done: got pend=%h ld_ready=%b, required 0 1", pend_mask, ld_ready); end
  endtask

  task automatic test_load_align();
    do_load(5'd7,  3'b000, 2'd2, 32'h12804455, 3, 32'hFFFFFF80);
    do_load(5'd8,  3'b101, 2'd2, 32'h80017FFF, 1, 32'h00008001);
    do_load(5'd8,  3'b001, 2'd2, 32'h80017FFF, 2, 32'hFFFF8001);
    do_load(5'd8,  3'b001, 2'd0, 32'h80017FFF, 1, 32'h00007FFF);
    do_load(5'd11, 3'b100, 2'd3, 32'h12804455, 1, 32'h00000012);
    do_load(5'd11, 3'b000, 2'd1, 32'h12804455, 1, 32'h00000044);
    do_load(5'd31, 3'b000, 2'd0, 32'h000000F0, 1, 32'hFFFFFFF0);
    do_load(5'd1,  3'b010, 2'd3, 32'h89ABCDEF, 1, 32'h89ABCDEF);
    do_load(5'd2,  3'b111, 2'd1, 32'h00FF00FF, 1, 32'h00FF00FF);
  endtask

  task automatic test_collision();
    ld_issue = 1; ld_rd = 9; ld_funct3 = 3'b010; ld_addr_lo = 0;
    tick();
    ld_issue = 0; mem_rvalid = 1; mem_rdata = 32'hA5A50001;
    sb.push_back('{5'd9, 32'hA5A50001});
    tick();
    mem_rvalid = 0;
    alu_valid = 1; alu_rd = 3; alu_result = 32'h00000033;
    n_cmp++; if (alu_ready !== 1'b0) begin n_err++; $display("FAIL col_alu_blocked: got %b, required 0", alu_ready); end
    sb.push_back('{5'd3, 32'h00000033});
    tick();
    n_cmp++; if (RegWr !== 1'b1 || write_reg !== 5'd9) begin n_err++; $display("FAIL col_load_first: got we=%b x%0d, required 1 x9", RegWr, write_reg); end
    n_cmp++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL col_alu_ready: got %b, required 1", alu_ready); end
    tick();
    alu_valid = 0;
    n_cmp++; if (RegWr !== 1'b1 || write_reg !== 5'd3) begin n_err++; $display("FAIL col_alu_second: got we=%b x%0d, required 1 x3", RegWr, write_reg); end
    tick();
    n_cmp++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL col_pulse: got %b, required 0", RegWr); end
  endtask

  task automatic test_alu_during_load();
    ld_issue = 1; ld_rd = 10; ld_funct3 = 3'b100; ld_addr_lo = 1;
    alu_valid = 1; alu_rd = 4; alu_result = 32'h44;
    sb.push_back('{5'd4, 32'h44});
    tick();
    ld_issue = 0; alu_rd = 6; alu_result = 32'h66;
    n_cmp++; if (RegWr !== 1'b1 || write_reg !== 5'd4) begin n_err++; $display("FAIL dual_alu: got we=%b x%0d, required 1 x4", RegWr, write_reg); end
    n_cmp++; if (alu_ready !== 1'b1 || pend_mask !== 32'h400) begin n_err++; $display("FAIL dual_wait: got alu_ready=%b pend=%h, required 1 00000400", alu_ready, pend_mask); end
    sb.push_back('{5'd6, 32'h66});
    tick();
    alu_valid = 0;
    n_cmp++; if (write_reg !== 5'd6) begin n_err++; $display("FAIL wait_alu: got x%0d, required x6", write_reg); end
    mem_rvalid = 1; mem_rdata = 32'h0000C300;
    sb.push_back('{5'd10, 32'h000000C3});
    tick();
    mem_rvalid = 0;
    tick();
    n_cmp++; if (write_reg !== 5'd10 || write_data !== 32'hC3) begin n_err++; $display("FAIL dual_load: got x%0d=%h, required x10=000000c3", write_reg, write_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(20 + i); alu_result = 32'h1000 * (i + 1) + 32'(i);
      sb.push_back('{alu_rd, alu_result});
      tick();
      if (i > 0) begin
        n_cmp++; if (RegWr !== 1'b1) begin n_err++; $display("FAIL b2b_regwr: got %b, required 1", RegWr); end
      end
    end
    alu_valid = 0;
    tick();
    n_cmp++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b, required 0", RegWr); end
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_result = 32'h12345678;
    tick();
    alu_valid = 0;
    n_cmp++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL x0_alu_regwr: got %b, required 0", RegWr); end
    n_cmp++; if (write_reg !== 5'd0 || write_data !== 32'h12345678) begin n_err++; $display("FAIL x0_alu_port: got x%0d=%h, required x0=12345678", write_reg, write_data); end
    tick();
    do_load(5'd0, 3'b010, 2'd0, 32'hCAFEF00D, 2, 32'hCAFEF00D);
  endtask

  task automatic test_reset_midload();
    ld_issue = 1; ld_rd = 12; ld_funct3 = 3'b001; ld_addr_lo = 0;
    tick();
    ld_issue = 0;
    n_cmp++; if (pend_mask !== 32'h1000) begin n_err++; $display("FAIL mid_pend: got %h, required 00001000", pend_mask); end
    tick();
    rst = 1;
    #1;
    n_cmp++; if (pend_mask !== 32'd0 || mem_rready !== 1'b0) begin n_err++; $display("FAIL mid_rst: got pend=%h mem_rready=%b, required 0 0", pend_mask, mem_rready); end
    n_cmp++; if (RegWr !== 1'b0 || write_data !== 32'd0 || write_reg !== 5'd0) begin n_err++; $display("FAIL mid_rst_port: got we=%b x%0d=%h, required 0 x0=0", RegWr, write_reg, write_data); end
    tick(); tick();
    rst = 0;
    #1;
    n_cmp++; if (ld_ready !== 1'b1 || mem_rready !== 1'b0) begin n_err++; $display("FAIL mid_release: got ld_ready=%b mem_rready=%b, required 1 0", ld_ready, mem_rready); end
    mem_rvalid = 1; mem_rdata = 32'h7777_8888;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (RegWr !== 1'b0) begin n_err++; $display("FAIL mid_stale_write: got %b, required 0", RegWr); end
    end
    mem_rvalid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_align();
    test_collision();
    test_alu_during_load();
    test_back_to_back();
    test_x0();
    test_reset_midload();
    tick(); tick();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage for the single-issue RV32I core; the write-side producer for the 32x32 register file. Accepts single-cycle ALU results and, through a valid/ready handshake, one outstanding data-memory load. Aligns and sign/zero-extends load data, arbitrates between the two sources, and drives the register file write port (RegWr, write_reg, write_data). Exports a pending-load scoreboard so decode can stall on load-use hazards.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  REG_AW  ALU destination register
- alu_result  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- ld_issue  in  1  load issued to memory this cycle
- ld_rd  in  REG_AW  load destination register
- ld_funct3  in  3  load type (LB/LH/LW/LBU/LHU)
- ld_addr_lo  in  2  byte offset of load address
- ld_ready  out  1  load slot free; ld_issue honoured only when high
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  raw aligned-word load data
- mem_rready  out  1  ready for load data
- RegWr  out  1  register file write enable
- write_reg  out  REG_AW  register file write address
- write_data  out  XLEN  register file write data
- pend_mask  out  2**REG_AW  one-hot of register awaiting load data

## Operation
- FSM states: IDLE, LOAD_WAIT, LOAD_WB.
- IDLE: ld_ready=1. On ld_issue, capture ld_rd, ld_funct3, ld_addr_lo; go LOAD_WAIT.
- LOAD_WAIT: mem_rready=1. On mem_rvalid, apply load_align to mem_rdata with captured funct3/addr_lo, store result; go LOAD_WB. Otherwise stay indefinitely.
- LOAD_WB: load result loaded into write port; go IDLE next cycle. ld_ready=0, alu_ready=0.
- alu_ready=1 in IDLE and LOAD_WAIT; a result is accepted when alu_valid && alu_ready. alu_valid is held by upstream while alu_ready=0.
- Same-cycle ld_issue and alu_valid in IDLE: both accepted.
- load_align: LB sign-extend byte[addr_lo]; LBU zero-extend byte[addr_lo]; LH sign-extend half[addr_lo[1]]; LHU zero-extend half[addr_lo[1]]; LW pass-through, addr_lo ignored. funct3 011/110/111 treated as LW.
- Destination x0: write port RegWr stays 0 (write_reg/write_data still updated); load handshake still completes normally.
- pend_mask: bit captured rd set while state is LOAD_WAIT or LOAD_WB; bit 0 never set; all zero in IDLE.

## Timing
- Write port outputs registered. ALU accept at cycle N -> RegWr=1, write_reg/write_data valid during N+1 only.
- Load: mem_rvalid&&mem_rready at N -> state LOAD_WB in N+1 -> RegWr=1 with load data during N+2.
- Earliest next ld_issue accepted in cycle N+2 (IDLE).
- RegWr is a single-cycle pulse per accepted write; 0 in every cycle without an accepted write.
- Reset (any cycle, including mid-load): state IDLE, RegWr=0, write_reg=0, write_data=0, pend_mask=0, captured load fields 0; outstanding load dropped. Combinational outputs after reset: ld_ready=1, alu_ready=1, mem_rready=0.

## Structure
- Shared riscv_pkg: load funct3 constants (F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101); wb_state_t enum {IDLE, LOAD_WAIT, LOAD_WB}.
- Sub-module load_align: combinational, inputs funct3, addr_lo, rdata; output extended XLEN data.

## Test plan
- ALU write: alu_valid, alu_rd=5, alu_result=0xDEADBEEF at N -> RegWr=1, write_reg=5, write_data=0xDEADBEEF at N+1; RegWr=0 at N+2.
- LB sign: ld_issue rd=7 funct3=000 addr_lo=2; mem_rvalid 3 cycles later with rdata=0x12804455 -> write_data=0xFFFFFF80 to x7 two cycles after handshake; pend_mask=0x80 until then.
- LHU/LH: rdata=0x8001_7FFF, addr_lo=2 -> LHU 0x00008001, LH 0xFFFF8001; addr_lo=0 LH -> 0x00007FFF.
- Collision: load in LOAD_WB while alu_valid rd=3 held -> alu_ready=0 that cycle; load written first, ALU write of x3 next cycle; no write lost.
- x0: ALU rd=0 and load rd=0 -> RegWr never asserted, load handshake completes, pend_mask stays 0.
- Reset mid-load: rst during LOAD_WAIT -> pend_mask=0, mem_rready=0 while rst held, ld_ready=1 after release, later mem_rvalid produces no write.
